// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and its consumers.
// Contract: no valid/ready here; every field is registered and changes only
// on clk, so all fields of one cycle describe the same (hcount, vcount) point,
// and line_start/frame_start are single-clk strobes qualified by nothing else.
interface vga_timing_gen_if;
  logic       en;
  logic       restart;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  en,
    input  restart,
    output hcount,
    output vcount,
    output hsync,
    output vsync,
    output active,
    output line_start,
    output frame_start
  );

  modport slave (
    output en,
    output restart,
    input  hcount,
    input  vcount,
    input  hsync,
    input  vsync,
    input  active,
    input  line_start,
    input  frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, and
// registered sync/active/strobe outputs aligned with the counts they describe.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] H_ACT_BEG  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_END  = 10'(H_SYNC + H_BP + H_ACTIVE);

  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] V_ACT_BEG  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_ACT_END  = 10'(V_SYNC + V_BP + V_ACTIVE);

  localparam logic [2:0] DIV_LAST   = 3'(CLK_DIV - 1);

  logic [2:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       act_q, act_d;
  logic       ls_q, ls_d;
  logic       fs_q, fs_d;
  logic       restart_q;

  logic tick;
  logic h_wrap;
  logic v_wrap;
  logic restart_edge;

  assign tick         = vga.en && (div_q == DIV_LAST);
  assign h_wrap       = tick && (h_q == H_LAST);
  assign v_wrap       = h_wrap && (v_q == V_LAST);
  // A held restart keeps the counts parked but strobes only once.
  assign restart_edge = vga.restart && !restart_q;

  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (vga.restart) begin
      div_d = 3'd0;
      h_d   = 10'd0;
      v_d   = 10'd0;
    end else if (vga.en) begin
      div_d = tick ? 3'd0 : div_q + 3'd1;
      if (tick) begin
        h_d = h_wrap ? 10'd0 : h_q + 10'd1;
        if (h_wrap) begin
          v_d = v_wrap ? 10'd0 : v_q + 10'd1;
        end
      end
    end
  end

  // Decode from the next counts so the registered flags land with them.
  always_comb begin
    hs_d  = (h_d < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    vs_d  = (v_d < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    act_d = (h_d >= H_ACT_BEG) && (h_d < H_ACT_END) &&
            (v_d >= V_ACT_BEG) && (v_d < V_ACT_END);
    ls_d  = vga.restart ? restart_edge : h_wrap;
    fs_d  = vga.restart ? restart_edge : v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= 3'd0;
      h_q       <= 10'd0;
      v_q       <= 10'd0;
      hs_q      <= SYNC_POL;
      vs_q      <= SYNC_POL;
      act_q     <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      act_q     <= act_d;
      ls_q      <= ls_d;
      fs_q      <= fs_d;
      restart_q <= vga.restart;
    end
  end

  assign vga.hcount      = h_q;
  assign vga.vcount      = v_q;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.active      = act_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size instance and a tiny-raster instance
// (12x7, CLK_DIV=2, positive sync) driven by directed, hand-timed sequences.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [19:0] cyc;
    logic        sel;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        act;
    logic        ls;
    logic        fs;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_timing_gen_if d_if ();
  vga_timing_gen_if s_if ();

  vga_timing_gen u_def (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (d_if)
  );

  vga_timing_gen #(
    .CLK_DIV  (2),
    .H_SYNC   (3),
    .H_BP     (2),
    .H_ACTIVE (5),
    .H_FP     (2),
    .V_SYNC   (2),
    .V_BP     (1),
    .V_ACTIVE (3),
    .V_FP     (1),
    .SYNC_POL (1'b1)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (s_if)
  );

  logic [24:0] obs_d, obs_s;
  assign obs_d = {d_if.hcount, d_if.vcount, d_if.hsync, d_if.vsync,
                  d_if.active, d_if.line_start, d_if.frame_start};
  assign obs_s = {s_if.hcount, s_if.vcount, s_if.hsync, s_if.vsync,
                  s_if.active, s_if.line_start, s_if.frame_start};

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  string            tag_q[$];
  int               n_pass = 0;
  int               n_total = 0;

  task automatic check_obs(input string tag, input logic [24:0] got, input logic [24:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b",
                  tag, got[24:15], got[14:5], got[4], got[3], got[2], got[1], got[0],
                  want[24:15], want[14:5], want[4], want[3], want[2], want[1], want[0]);
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, want);
  endtask

  // ---------------- driver tasks ----------------
  task automatic expect_obs(input string tag, input int k, input bit sel,
                            input int h, input int v, input bit hs, input bit vs,
                            input bit act, input bit ls, input bit fs);
    exp_t e;
    e.cyc = 20'(k);
    e.sel = sel;
    e.h   = 10'(h);
    e.v   = 10'(v);
    e.hs  = hs;
    e.vs  = vs;
    e.act = act;
    e.ls  = ls;
    e.fs  = fs;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic goto(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t        e;
    logic [24:0] got;
    logic [24:0] want;
    forever begin
      @(negedge clk);
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        e = exp_t'(exp_q[i]);
        if (int'(e.cyc) <= cyc) begin
          got  = e.sel ? obs_s : obs_d;
          want = {e.h, e.v, e.hs, e.vs, e.act, e.ls, e.fs};
          if (int'(e.cyc) < cyc) begin
            n_total++;
            $display("FAIL %s: observed late at cycle %0d, due at %0d", tag_q[i], cyc, e.cyc);
          end else begin
            check_obs(tag_q[i], got, want);
          end
          exp_q.delete(i);
          tag_q.delete(i);
        end
      end
    end
  end

  // Per-frame statistics of the tiny raster, captured for the first full frame.
  int fs_seen = 0, stats_done = 0, fs_cyc = 0;
  int ls_cnt = 0, act_cnt = 0;
  int fr_period = 0, fr_lines = 0, fr_active = 0;

  initial begin : frame_stats
    forever begin
      @(negedge clk);
      if (s_if.frame_start) begin
        if (fs_seen != 0 && stats_done == 0) begin
          fr_period  = cyc - fs_cyc;
          fr_lines   = ls_cnt;
          fr_active  = act_cnt;
          stats_done = 1;
        end
        fs_seen = 1;
        fs_cyc  = cyc;
        ls_cnt  = 0;
        act_cnt = 0;
      end
      if (s_if.line_start) ls_cnt++;
      if (s_if.active) act_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  int b, c0;

  initial begin : stimulus
    rst_n        = 1'b0;
    d_if.en      = 1'b0;
    d_if.restart = 1'b0;
    s_if.en      = 1'b0;
    s_if.restart = 1'b0;

    repeat (3) @(negedge clk);
    expect_obs("d_reset", cyc + 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_obs("s_reset", cyc + 1, 1, 0, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);

    // Default raster runs; tiny raster stays frozen with en low.
    rst_n   = 1'b1;
    d_if.en = 1'b1;
    b = cyc;
    expect_obs("d_first",   b + 1,    0, 0,   0, 0, 0, 0, 0, 0);
    expect_obs("d_adv",     b + 2,    0, 1,   0, 0, 0, 0, 0, 0);
    expect_obs("s_frozen",  b + 100,  1, 0,   0, 1, 1, 0, 0, 0);
    expect_obs("d_hs95",    b + 191,  0, 95,  0, 0, 0, 0, 0, 0);
    expect_obs("d_hs96",    b + 192,  0, 96,  0, 1, 0, 0, 0, 0);
    expect_obs("d_h144v0",  b + 288,  0, 144, 0, 1, 0, 0, 0, 0);
    expect_obs("d_h799",    b + 1599, 0, 799, 0, 1, 0, 0, 0, 0);
    expect_obs("d_wrap",    b + 1600, 0, 0,   1, 0, 0, 0, 1, 0);
    expect_obs("d_wrap1",   b + 1601, 0, 0,   1, 0, 0, 0, 0, 0);
    expect_obs("d_v2",      b + 3200, 0, 0,   2, 0, 1, 0, 1, 0);
    goto(b + 3210);

    s_if.en = 1'b1;
    c0 = cyc;
    expect_obs("s_k1",      c0 + 1,   1, 0,  0, 1, 1, 0, 0, 0);
    expect_obs("s_k2",      c0 + 2,   1, 1,  0, 1, 1, 0, 0, 0);
    expect_obs("s_h3",      c0 + 6,   1, 3,  0, 0, 1, 0, 0, 0);
    expect_obs("s_line1",   c0 + 24,  1, 0,  1, 1, 1, 0, 1, 0);
    expect_obs("s_line1b",  c0 + 25,  1, 0,  1, 1, 1, 0, 0, 0);
    expect_obs("s_h5v2",    c0 + 58,  1, 5,  2, 0, 0, 0, 0, 0);
    expect_obs("s_h4v3",    c0 + 81,  1, 4,  3, 0, 0, 0, 0, 0);
    expect_obs("s_h5v3",    c0 + 82,  1, 5,  3, 0, 0, 1, 0, 0);
    expect_obs("s_h9v3",    c0 + 91,  1, 9,  3, 0, 0, 1, 0, 0);
    expect_obs("s_h10v3",   c0 + 92,  1, 10, 3, 0, 0, 0, 0, 0);
    expect_obs("s_h5v5",    c0 + 130, 1, 5,  5, 0, 0, 1, 0, 0);
    expect_obs("s_h5v6",    c0 + 154, 1, 5,  6, 0, 0, 0, 0, 0);
    expect_obs("s_last",    c0 + 167, 1, 11, 6, 0, 0, 0, 0, 0);
    expect_obs("s_frame",   c0 + 168, 1, 0,  0, 1, 1, 0, 1, 1);
    expect_obs("s_frame1",  c0 + 169, 1, 0,  0, 1, 1, 0, 0, 0);
    expect_obs("s_frame2",  c0 + 336, 1, 0,  0, 1, 1, 0, 1, 1);
    // Freeze mid-pixel, then freeze on a line_start clk.
    expect_obs("s_frzA0",   c0 + 342, 1, 2,  0, 1, 1, 0, 0, 0);
    expect_obs("s_frzA1",   c0 + 358, 1, 2,  0, 1, 1, 0, 0, 0);
    expect_obs("s_resA",    c0 + 359, 1, 3,  0, 0, 1, 0, 0, 0);
    expect_obs("s_resA1",   c0 + 360, 1, 3,  0, 0, 1, 0, 0, 0);
    expect_obs("s_lsB",     c0 + 377, 1, 0,  1, 1, 1, 0, 1, 0);
    expect_obs("s_frzB0",   c0 + 378, 1, 0,  1, 1, 1, 0, 0, 0);
    expect_obs("s_frzB1",   c0 + 394, 1, 0,  1, 1, 1, 0, 0, 0);
    expect_obs("s_resB0",   c0 + 395, 1, 0,  1, 1, 1, 0, 0, 0);
    expect_obs("s_resB1",   c0 + 396, 1, 1,  1, 1, 1, 0, 0, 0);
    // Restart pulse with en low, then restart held with en high.
    expect_obs("s_rst_en0", c0 + 401, 1, 0,  0, 1, 1, 0, 1, 1);
    expect_obs("s_hold0",   c0 + 402, 1, 0,  0, 1, 1, 0, 0, 0);
    expect_obs("s_hold1",   c0 + 410, 1, 0,  0, 1, 1, 0, 0, 0);
    expect_obs("s_hold2",   c0 + 411, 1, 0,  0, 1, 1, 0, 0, 0);
    expect_obs("s_go",      c0 + 412, 1, 1,  0, 1, 1, 0, 0, 0);
    expect_obs("s_rhold0",  c0 + 421, 1, 0,  0, 1, 1, 0, 1, 1);
    expect_obs("s_rhold1",  c0 + 422, 1, 0,  0, 1, 1, 0, 0, 0);
    expect_obs("s_rhold2",  c0 + 423, 1, 0,  0, 1, 1, 0, 0, 0);
    expect_obs("s_rrel0",   c0 + 424, 1, 0,  0, 1, 1, 0, 0, 0);
    expect_obs("s_rrel1",   c0 + 425, 1, 1,  0, 1, 1, 0, 0, 0);

    goto(c0 + 341); s_if.en = 1'b0;
    goto(c0 + 358); s_if.en = 1'b1;
    goto(c0 + 377); s_if.en = 1'b0;
    goto(c0 + 394); s_if.en = 1'b1;
    goto(c0 + 400); s_if.en = 1'b0; s_if.restart = 1'b1;
    goto(c0 + 401); s_if.restart = 1'b0;
    goto(c0 + 410); s_if.en = 1'b1;
    goto(c0 + 420); s_if.restart = 1'b1;
    goto(c0 + 423); s_if.restart = 1'b0;

    // Asynchronous reset between edges, checked before the next posedge.
    goto(c0 + 439);
    expect_obs("d_async",   c0 + 440, 0, 0,  0, 0, 0, 0, 0, 0);
    expect_obs("s_async",   c0 + 440, 1, 0,  0, 1, 1, 0, 0, 0);
    expect_obs("d_por0",    c0 + 444, 0, 0,  0, 0, 0, 0, 0, 0);
    expect_obs("d_por1",    c0 + 445, 0, 1,  0, 0, 0, 0, 0, 0);
    expect_obs("s_por0",    c0 + 444, 1, 0,  0, 1, 1, 0, 0, 0);
    expect_obs("s_por1",    c0 + 445, 1, 1,  0, 1, 1, 0, 0, 0);
    expect_obs("s_porlast", c0 + 610, 1, 11, 6, 0, 0, 0, 0, 0);
    expect_obs("s_porfs",   c0 + 611, 1, 0,  0, 1, 1, 0, 1, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    goto(c0 + 443); rst_n = 1'b1;
    goto(c0 + 620);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    while (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL %s: never observed", tag_q[0]);
      void'(exp_q.pop_front());
      void'(tag_q.pop_front());
    end

    check_val("frame_period", fr_period, 168);
    check_val("lines_per_frame", fr_lines, 7);
    check_val("active_clks_per_frame", fr_active, 30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001: Parameter CLK_DIV, 2: clk cycles per pixel; legal values are 1 to 8.
REQ-002: Parameters H_SYNC/H_BP/H_ACTIVE/H_FP, 96/48/640/16: horizontal segment lengths, in pixels.
REQ-003: Parameters V_SYNC/V_BP/V_ACTIVE/V_FP, 2/33/480/10: vertical segment lengths, in lines.
REQ-004: Parameter SYNC_POL, 1'b0: the asserted level of hsync and vsync.
REQ-005: clk  in  1  system clock; one clock domain only.
REQ-006: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007: en  in  1  run enable; while low, timing freezes.
REQ-008: restart  in  1  synchronous restart to count (0,0).
REQ-009: hcount  out  10  horizontal pixel counter; this is the data1 feed of the display-window stage.
REQ-010: vcount  out  10  vertical line counter; this is the data2 feed of the display-window stage.
REQ-011: hsync  out  1  horizontal sync.
REQ-012: vsync  out  1  vertical sync.
REQ-013: active  out  1  high when (hcount,vcount) lies in the visible region.
REQ-014: line_start  out  1  one-clk pulse at the start of each line.
REQ-015: frame_start  out  1  one-clk pulse at the start of each frame.

Function
REQ-016: H_TOTAL SHALL equal H_SYNC+H_BP+H_ACTIVE+H_FP (800 by default), and V_TOTAL SHALL equal V_SYNC+V_BP+V_ACTIVE+V_FP (525 by default).
REQ-017: Counter origin SHALL be the start of sync; segment order is sync, back porch, active, front porch. With defaults, h active is 144..783 and v active is 35..514.
REQ-018: A divider counter div SHALL run 0..CLK_DIV-1 while en=1. tick SHALL be true when div==CLK_DIV-1 and en=1. When CLK_DIV=1, tick SHALL equal en.
REQ-019: On tick, hcount SHALL increment. At H_TOTAL-1, hcount SHALL wrap to 0 and vcount SHALL increment in the same clk.
REQ-020: vcount SHALL wrap from V_TOTAL-1 to 0 only on the tick on which hcount wraps.
REQ-021: hcount SHALL never exceed H_TOTAL-1, and vcount SHALL never exceed V_TOTAL-1.
REQ-022: All outputs SHALL be registered. hsync, vsync and active SHALL describe the hcount/vcount values presented in the same cycle, with zero relative skew.
REQ-023: hsync SHALL be SYNC_POL iff hcount<H_SYNC; otherwise it SHALL be ~SYNC_POL.
REQ-024: vsync SHALL be SYNC_POL iff vcount<V_SYNC; otherwise it SHALL be ~SYNC_POL.
REQ-025: active SHALL be 1 iff H_SYNC+H_BP <= hcount < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= vcount < V_SYNC+V_BP+V_ACTIVE.
REQ-026: line_start SHALL be 1 for exactly one clk: the first clk in which hcount presents 0 after a wrap or restart. It SHALL NOT stay high for the remaining CLK_DIV-1 clks of that pixel.
REQ-027: frame_start SHALL be 1 for exactly one clk: the first clk in which hcount=0 and vcount=0 are presented after a wrap or restart. When frame_start is 1, line_start SHALL also be 1.
REQ-028: en=0 SHALL hold div, hcount, vcount, hsync, vsync and active, and SHALL force line_start and frame_start to 0. Resuming SHALL continue from the held div value.
REQ-029: restart=1 SHALL take priority over en. On the next clk, div=0, hcount=0, vcount=0, and line_start=frame_start=1; hsync, vsync and active SHALL be consistent with (0,0).
REQ-030: restart held high for several clks SHALL keep the counts at (0,0) with div=0. Each pulse SHALL assert only on the first restart clk.
REQ-031: restart SHALL be honoured when en=0 and SHALL produce the same result as with en=1.

Reset
REQ-032: rst_n=0 SHALL immediately set div=0, hcount=0, vcount=0, hsync=SYNC_POL, vsync=SYNC_POL, active=0, line_start=0, frame_start=0.
REQ-033: After rst_n rises, the first tick SHALL advance hcount to 1. No frame_start SHALL be issued for the reset frame.
REQ-034: Reset asserted mid-frame SHALL abort the frame with no partial pulses, and SHALL produce the same post-release sequence as a power-on reset.

Verification
REQ-035: Defaults, en=1, 2 full frames: the period from frame_start to frame_start SHALL be 800*525*2 = 840000 clks. Each frame SHALL have 525 line_start pulses and 307200 active pixels.
REQ-036: Boundaries: hcount=143 -> active=0; hcount=144 with vcount=35 -> active=1; hcount=783 -> active=1; hcount=784 -> active=0. hsync=0 at hcount 0..95 and 1 at hcount 96.
REQ-037: Wrap: when (hcount,vcount)=(799,524) and a tick occurs, the next clk SHALL present (0,0) with frame_start=1, line_start=1, vsync=0 and hsync=0.
REQ-038: With the counts at (300,100), drop en for 17 clks then raise it: the counts SHALL stay frozen, with no pulses. The pixel SHALL then last its remaining div clks, followed by hcount=301.
REQ-039: restart pulse at (500,200) with en=0: the next clk SHALL give (0,0) with frame_start=1. The counts SHALL hold there until en=1.
REQ-040: Reset asserted asynchronously at (650,400), between clk edges: outputs SHALL go immediately to REQ-032 values. After release, with CLK_DIV=2, hcount=1 SHALL appear 2 clks later.
